// File: rtl/spi_test_pkg.sv
// Shared opcodes, widths and state encoding for the SPI test device.
package spi_test_pkg;

    localparam int unsigned CMD_W      = 8;
    localparam int unsigned WORD_W     = 16;
    localparam int unsigned BIT_CNT_W  = 3;
    localparam int unsigned RESP_CNT_W = 4;

    localparam logic [CMD_W-1:0] CMD_READ   = 8'h03;
    localparam logic [CMD_W-1:0] CMD_STATUS = 8'h05;
    localparam logic [CMD_W-1:0] CMD_ID     = 8'h9F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/spi_test_device.sv
// SPI mode-0 test slave: 8-bit command in, then an endless response stream
// (ID word, status byte or incrementing 16-bit samples) until csb rises.
module spi_test_device
    import spi_test_pkg::*;
#(
    parameter logic [WORD_W-1:0] ID_WORD     = 16'hA55A,
    parameter logic [CMD_W-1:0]  STATUS_BYTE = 8'h80
) (
    input  logic clk,
    input  logic csb,
    input  logic sdi,
    output logic sdo
);

    state_t                  state;
    state_t                  state_nxt;
    logic [BIT_CNT_W-1:0]    bit_cnt;
    logic [CMD_W-2:0]        cmd_sr;
    logic [CMD_W-1:0]        cmd;
    logic [WORD_W-1:0]       shift_sr;
    logic [WORD_W-1:0]       sample_cnt;
    logic [RESP_CNT_W-1:0]   resp_cnt;
    logic [RESP_CNT_W-1:0]   resp_last_c;

    // State register; csb high holds the FSM in IDLE.
    always_ff @(posedge clk or posedge csb) begin
        if (csb) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: first edge enters CMD, edge 8 enters RESP, RESP exits only via csb.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: state_nxt = ST_CMD;
            ST_CMD:  if (bit_cnt == BIT_CNT_W'(7)) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_RESP;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Rising-edge path: shift in the command byte, counter saturates at 7.
    always_ff @(posedge clk or posedge csb) begin
        if (csb) begin
            bit_cnt <= '0;
            cmd_sr  <= '0;
            cmd     <= '0;
        end else if (state != ST_RESP) begin
            cmd_sr <= {cmd_sr[CMD_W-3:0], sdi};
            if (bit_cnt == BIT_CNT_W'(7)) begin
                cmd <= {cmd_sr, sdi};
            end else begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
        end
    end

    // Reload period of the response shifter: 8 bits for STATUS, else 16.
    always_comb begin
        resp_last_c = RESP_CNT_W'(15);
        if (cmd == CMD_STATUS) resp_last_c = RESP_CNT_W'(7);
    end

    // Falling-edge path: load a fresh response word at each period start, else shift.
    always_ff @(negedge clk or posedge csb) begin
        if (csb) begin
            shift_sr   <= '0;
            sample_cnt <= '0;
            resp_cnt   <= '0;
        end else if (state == ST_RESP) begin
            if (resp_cnt == '0) begin
                case (cmd)
                    CMD_ID:     shift_sr <= ID_WORD;
                    CMD_STATUS: shift_sr <= {STATUS_BYTE, 8'h00};
                    CMD_READ: begin
                        shift_sr   <= sample_cnt;
                        sample_cnt <= sample_cnt + WORD_W'(1);
                    end
                    default:    shift_sr <= '0;
                endcase
            end else begin
                shift_sr <= {shift_sr[WORD_W-2:0], 1'b0};
            end
            resp_cnt <= (resp_cnt == resp_last_c) ? '0 : resp_cnt + RESP_CNT_W'(1);
        end
    end

    assign sdo = shift_sr[WORD_W-1];

endmodule

// File: tb/tb_spi_test_device.sv
// Directed bench for spi_test_device: ID, STATUS, READ, abort, unknown command, wrap.
module tb_spi_test_device;

    logic clk = 1'b0;
    logic csb = 1'b1;
    logic sdi = 1'b0;
    logic sdo;

    int n_checks = 0;
    int n_pass   = 0;

    spi_test_device dut (
        .clk (clk),
        .csb (csb),
        .sdi (sdi),
        .sdo (sdo)
    );

    // Compare observed against expected and count the result.
    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // One SPI bit: drive sdi while clk low, rise, sample sdo mid-high, fall.
    task automatic xfer(input logic din, output logic dout);
        sdi = din;
        #5 clk = 1'b1;
        #1 dout = sdo;
        #4 clk = 1'b0;
    endtask

    task automatic start_frame();
        csb = 1'b0;
        #5;
    endtask

    task automatic end_frame();
        #5 csb = 1'b1;
        #5;
    endtask

    // Send a command byte MSB first, returning what sdo showed meanwhile.
    task automatic send_cmd(input logic [7:0] c, output logic [7:0] seen);
        logic b;
        seen = '0;
        for (int i = 0; i < 8; i++) begin
            xfer(c[7-i], b);
            seen = {seen[6:0], b};
        end
    endtask

    // Clock n response bits (sdi toggling, which must be ignored).
    task automatic read_bits(input int n, output logic [47:0] r);
        logic b;
        r = '0;
        for (int i = 0; i < n; i++) begin
            xfer(1'(i), b);
            r = {r[46:0], b};
        end
    endtask

    initial begin
        logic [7:0]  seen;
        logic [47:0] r;
        logic [47:0] r2;
        logic        acc;
        logic        b;

        #10;
        check("reset_sdo", 48'(sdo), 48'h0);

        // ID command: two repeats of the ID word
        start_frame();
        send_cmd(8'h9F, seen);
        check("id_cmd_phase_sdo", 48'(seen), 48'h0);
        read_bits(32, r);
        check("id_word0", 48'(r[31:16]), 48'hA55A);
        check("id_word1", 48'(r[15:0]),  48'hA55A);
        end_frame();

        // STATUS command: byte repeats every 8 bits
        start_frame();
        send_cmd(8'h05, seen);
        check("status_cmd_phase_sdo", 48'(seen), 48'h0);
        read_bits(16, r);
        check("status_byte0", 48'(r[15:8]), 48'h80);
        check("status_byte1", 48'(r[7:0]),  48'h80);
        end_frame();

        // READ command: incrementing samples from zero
        start_frame();
        send_cmd(8'h03, seen);
        read_bits(48, r);
        check("read_sample0", 48'(r[47:32]), 48'h0000);
        check("read_sample1", 48'(r[31:16]), 48'h0001);
        check("read_sample2", 48'(r[15:0]),  48'h0002);
        end_frame();

        // Abort mid-sample, then restart from sample zero
        start_frame();
        send_cmd(8'h03, seen);
        read_bits(5, r);
        check("abort_partial_bits", 48'(r[4:0]), 48'h0);
        end_frame();
        check("abort_sdo_idle", 48'(sdo), 48'h0);
        start_frame();
        send_cmd(8'h03, seen);
        read_bits(32, r);
        check("restart_sample0", 48'(r[31:16]), 48'h0000);
        check("restart_sample1", 48'(r[15:0]),  48'h0001);
        end_frame();

        // Unknown command streams zeros
        start_frame();
        send_cmd(8'h42, seen);
        read_bits(16, r);
        check("unknown_resp", 48'(r[15:0]), 48'h0);
        end_frame();

        // Clock activity with csb high does nothing
        acc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            xfer(1'b1, b);
            acc = acc | b;
        end
        check("csb_high_clocking_sdo", 48'(acc), 48'h0);

        // Wrap: preload counter to FFFF during sample 0, then FFFF, 0000 follow
        start_frame();
        send_cmd(8'h03, seen);
        read_bits(15, r);
        force dut.sample_cnt = 16'hFFFF;
        #1 release dut.sample_cnt;
        read_bits(1, r2);
        r = {r[46:0], r2[0]};
        check("wrap_sample0", 48'(r[15:0]), 48'h0000);
        read_bits(32, r);
        check("wrap_sample_ffff", 48'(r[31:16]), 48'hFFFF);
        check("wrap_sample_next", 48'(r[15:0]),  48'h0000);
        end_frame();
        check("final_sdo_idle", 48'(sdo), 48'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
